// File: rtl/safe_lock_if.sv
// Keypad/button inputs and display outputs of the safe controller.
// The scanner/display side drives through master; the controller uses slave.
interface safe_lock_if;
   logic       row1;
   logic       row2;
   logic       row3;
   logic       row4;
   logic       col1;
   logic       col2;
   logic       col3;
   logic       reset_password;
   logic [5:0] password_led;
   logic [2:0] state;

   modport master (
      output row1, row2, row3, row4, col1, col2, col3, reset_password,
      input  password_led, state
   );

   modport slave (
      input  row1, row2, row3, row4, col1, col2, col3, reset_password,
      output password_led, state
   );
endinterface

// File: rtl/safe_lock.sv
// Digital safe controller: synchronised keypad decode, password entry/compare,
// power/open/lock state machine and password change while open.
module safe_lock (
   input  logic        clk,
   input  logic        initialize_n,
   safe_lock_if.slave  bus
);
   localparam int unsigned MAX_DIG = 6;
   localparam int unsigned DIG_W   = 4;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned SYNC_W  = 8;
   localparam logic [DIG_W-1:0] K_STAR = 4'd10;
   localparam logic [DIG_W-1:0] K_HASH = 4'd11;

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_ON    = 3'd1,
      S_W1    = 3'd2,
      S_W2    = 3'd3,
      S_OPEN  = 3'd4,
      S_RESET = 3'd5,
      S_BAD   = 3'd6,
      S_LOCK  = 3'd7
   } state_t;

   logic [SYNC_W-1:0]               r_sync1;
   logic [SYNC_W-1:0]               r_sync2;
   logic [1:0]                      r_fill;
   logic                            r_idle_seen;
   logic                            r_armed;
   logic                            r_rp_prev;
   state_t                          r_state;
   logic [MAX_DIG-1:0][DIG_W-1:0]   r_buf;
   logic [CNT_W-1:0]                r_cnt;
   logic [MAX_DIG-1:0][DIG_W-1:0]   r_pw;
   logic [CNT_W-1:0]                r_len;
   logic [MAX_DIG-1:0]              r_led;

   logic [3:0]                      w_rows;
   logic [2:0]                      w_cols;
   logic                            w_cols_low;
   logic                            w_key_valid;
   logic [DIG_W-1:0]                w_key;
   logic                            w_key_evt;
   logic                            w_rp_evt;
   logic                            w_is_digit;
   logic                            w_is_star;
   logic                            w_is_hash;
   logic                            w_match;
   logic [MAX_DIG-1:0][DIG_W-1:0]   w_app_buf;
   logic [CNT_W-1:0]                w_app_cnt;
   state_t                          w_state_nxt;
   logic [MAX_DIG-1:0][DIG_W-1:0]   w_buf_nxt;
   logic [CNT_W-1:0]                w_cnt_nxt;
   logic [MAX_DIG-1:0][DIG_W-1:0]   w_pw_nxt;
   logic [CNT_W-1:0]                w_len_nxt;
   logic [MAX_DIG-1:0]              w_led_nxt;

   // Two-stage synchroniser for all button inputs
   always_ff @(posedge clk or negedge initialize_n) begin
      if (!initialize_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_fill  <= '0;
      end else begin
         r_sync1 <= {bus.reset_password, bus.col3, bus.col2, bus.col1,
                     bus.row4, bus.row3, bus.row2, bus.row1};
         r_sync2 <= r_sync1;
         r_fill  <= {r_fill[0], 1'b1};
      end
   end

   assign w_rows     = r_sync2[3:0];
   assign w_cols     = r_sync2[6:4];
   assign w_cols_low = (w_cols == 3'b000);

   // Row/column to key code; anything but one row and one column is no key
   always_comb begin
      w_key_valid = 1'b1;
      w_key       = '0;
      case ({w_rows, w_cols})
         {4'b0001, 3'b001}: w_key = 4'd1;
         {4'b0001, 3'b010}: w_key = 4'd2;
         {4'b0001, 3'b100}: w_key = 4'd3;
         {4'b0010, 3'b001}: w_key = 4'd4;
         {4'b0010, 3'b010}: w_key = 4'd5;
         {4'b0010, 3'b100}: w_key = 4'd6;
         {4'b0100, 3'b001}: w_key = 4'd7;
         {4'b0100, 3'b010}: w_key = 4'd8;
         {4'b0100, 3'b100}: w_key = 4'd9;
         {4'b1000, 3'b001}: w_key = K_STAR;
         {4'b1000, 3'b010}: w_key = 4'd0;
         {4'b1000, 3'b100}: w_key = K_HASH;
         default: begin
            w_key_valid = 1'b0;
            w_key       = '0;
         end
      endcase
   end

   // The idle qualifier needs a full pipeline so a key held through reset never fires
   assign w_key_evt  = w_key_valid && r_armed && r_idle_seen;
   assign w_rp_evt   = r_sync2[7] && !r_rp_prev;
   assign w_is_digit = w_key_evt && (w_key <= 4'd9);
   assign w_is_star  = w_key_evt && (w_key == K_STAR);
   assign w_is_hash  = w_key_evt && (w_key == K_HASH);

   always_ff @(posedge clk or negedge initialize_n) begin
      if (!initialize_n) begin
         r_armed     <= 1'b1;
         r_idle_seen <= 1'b0;
         r_rp_prev   <= 1'b0;
      end else begin
         r_rp_prev <= r_sync2[7];
         if (r_fill[1] && w_cols_low) begin
            r_idle_seen <= 1'b1;
         end
         if (w_key_evt) begin
            r_armed <= 1'b0;
         end else if (w_cols_low) begin
            r_armed <= 1'b1;
         end
      end
   end

   // Buffer with the current key appended; digits beyond the sixth are dropped
   always_comb begin
      w_app_buf = r_buf;
      w_app_cnt = r_cnt;
      for (int i = 0; i < MAX_DIG; i++) begin
         if (CNT_W'(i) == r_cnt) begin
            w_app_buf[i] = w_key;
         end
      end
      if (r_cnt < CNT_W'(MAX_DIG)) begin
         w_app_cnt = r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_match = (r_cnt == r_len);
      for (int i = 0; i < MAX_DIG; i++) begin
         if ((CNT_W'(i) < r_cnt) && (r_buf[i] != r_pw[i])) begin
            w_match = 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_buf_nxt   = r_buf;
      w_cnt_nxt   = r_cnt;
      w_pw_nxt    = r_pw;
      w_len_nxt   = r_len;
      case (r_state)
         S_OFF: begin
            if (w_is_star) begin
               w_state_nxt = S_ON;
            end
         end
         S_ON, S_W1, S_W2: begin
            if (w_is_digit) begin
               w_buf_nxt = w_app_buf;
               w_cnt_nxt = w_app_cnt;
            end else if (w_is_star) begin
               w_state_nxt = S_OFF;
               w_buf_nxt   = '0;
               w_cnt_nxt   = '0;
            end else if (w_is_hash && (r_cnt != '0)) begin
               w_buf_nxt = '0;
               w_cnt_nxt = '0;
               if (w_match) begin
                  w_state_nxt = S_OPEN;
               end else if (r_state == S_ON) begin
                  w_state_nxt = S_W1;
               end else if (r_state == S_W1) begin
                  w_state_nxt = S_W2;
               end else begin
                  w_state_nxt = S_LOCK;
               end
            end
         end
         S_OPEN: begin
            if (w_rp_evt) begin
               w_state_nxt = S_RESET;
               w_buf_nxt   = '0;
               w_cnt_nxt   = '0;
            end else if (w_is_star) begin
               w_state_nxt = S_OFF;
            end
         end
         S_RESET: begin
            if (w_is_digit) begin
               w_buf_nxt = w_app_buf;
               w_cnt_nxt = w_app_cnt;
            end else if (w_is_hash && (r_cnt != '0)) begin
               w_pw_nxt    = r_buf;
               w_len_nxt   = r_cnt;
               w_buf_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_ON;
            end else if (w_is_star) begin
               w_buf_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_OPEN;
            end
         end
         S_LOCK: begin
            w_state_nxt = S_LOCK;
         end
         default: begin
            w_state_nxt = S_OFF;
            w_buf_nxt   = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Progress bar fills from bit 5 downward while digits are being entered
   always_comb begin
      w_led_nxt = '0;
      if ((w_state_nxt == S_ON) || (w_state_nxt == S_W1) ||
          (w_state_nxt == S_W2) || (w_state_nxt == S_RESET)) begin
         for (int i = 0; i < MAX_DIG; i++) begin
            w_led_nxt[MAX_DIG-1-i] = (CNT_W'(i) < w_cnt_nxt);
         end
      end
   end

   always_ff @(posedge clk or negedge initialize_n) begin
      if (!initialize_n) begin
         r_state <= S_OFF;
         r_buf   <= '0;
         r_cnt   <= '0;
         r_pw    <= {4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1};
         r_len   <= 3'd4;
         r_led   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_buf   <= w_buf_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pw    <= w_pw_nxt;
         r_len   <= w_len_nxt;
         r_led   <= w_led_nxt;
      end
   end

   assign bus.state        = r_state;
   assign bus.password_led = r_led;
endmodule

// File: tb/tb_safe_lock.sv
// Self-checking bench for safe_lock: directed scenarios plus random key traffic
// compared against a queue-based model of the safe's rules.
module tb_safe_lock;
   logic clk;
   logic initialize_n;
   int   n_total;
   int   n_bad;

   safe_lock_if bus ();

   safe_lock dut (
      .clk          (clk),
      .initialize_n (initialize_n),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: state code, entry buffer and password as digit queues
   int m_state;
   int m_buf[$];
   int m_pw[$];

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_led();
      int n;
      if (m_state inside {1, 2, 3, 5}) begin
         n = m_buf.size();
         return (((1 << n) - 1) << (6 - n)) & 63;
      end
      return 0;
   endfunction

   function automatic bit buf_matches();
      if (m_buf.size() != m_pw.size()) return 1'b0;
      foreach (m_buf[i]) if (m_buf[i] != m_pw[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_buf.delete();
      m_pw = '{1, 2, 3, 4};
   endtask

   // k: 0..9 digits, 10 = star, 11 = hash
   task automatic model_key(input int k);
      case (m_state)
         0: if (k == 10) m_state = 1;
         1, 2, 3: begin
            if (k <= 9) begin
               if (m_buf.size() < 6) m_buf.push_back(k);
            end else if (k == 10) begin
               m_state = 0;
               m_buf.delete();
            end else if (m_buf.size() > 0) begin
               m_state = buf_matches() ? 4 : ((m_state == 3) ? 7 : m_state + 1);
               m_buf.delete();
            end
         end
         4: if (k == 10) m_state = 0;
         5: begin
            if (k <= 9) begin
               if (m_buf.size() < 6) m_buf.push_back(k);
            end else if (k == 11) begin
               if (m_buf.size() > 0) begin
                  m_pw = m_buf;
                  m_buf.delete();
                  m_state = 1;
               end
            end else begin
               m_buf.delete();
               m_state = 4;
            end
         end
         default: ;
      endcase
   endtask

   task automatic model_rp();
      if (m_state == 4) begin
         m_state = 5;
         m_buf.delete();
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_keys();
      bus.row1 = 0; bus.row2 = 0; bus.row3 = 0; bus.row4 = 0;
      bus.col1 = 0; bus.col2 = 0; bus.col3 = 0;
   endtask

   task automatic set_key(input int k);
      int r;
      int c;
      if (k >= 1 && k <= 9) begin
         r = (k - 1) / 3;
         c = (k - 1) % 3;
      end else begin
         r = 3;
         c = (k == 10) ? 0 : ((k == 0) ? 1 : 2);
      end
      release_keys();
      bus.row1 = (r == 0); bus.row2 = (r == 1); bus.row3 = (r == 2); bus.row4 = (r == 3);
      bus.col1 = (c == 0); bus.col2 = (c == 1); bus.col3 = (c == 2);
   endtask

   task automatic check_out(input string tag);
      check({tag, "_state"}, int'(bus.state), m_state);
      check({tag, "_led"}, int'(bus.password_led), exp_led());
   endtask

   task automatic press(input int k);
      set_key(k);
      tick(4);
      model_key(k);
      check_out($sformatf("key%0d", k));
      release_keys();
      tick(3);
      check_out("release");
   endtask

   task automatic pulse_rp();
      bus.reset_password = 1;
      tick(4);
      model_rp();
      check_out("rp_high");
      bus.reset_password = 0;
      tick(3);
      check_out("rp_low");
   endtask

   task automatic star_and_rp();
      set_key(10);
      bus.reset_password = 1;
      tick(4);
      if (m_state == 4) model_rp();
      else model_key(10);
      check_out("star_rp");
      release_keys();
      bus.reset_password = 0;
      tick(3);
      check_out("star_rp_rel");
   endtask

   task automatic do_reset();
      initialize_n = 0;
      tick(2);
      check("rst_state", int'(bus.state), 0);
      check("rst_led", int'(bus.password_led), 0);
      model_reset();
      initialize_n = 1;
      tick(4);
      check_out("post_rst");
   endtask

   task automatic enter_pw();
      int d[$];
      d = m_pw;
      foreach (d[i]) press(d[i]);
      press(11);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      initialize_n = 0;
      bus.reset_password = 0;
      release_keys();
      model_reset();
      tick(2);
      do_reset();

      // Power-on and correct password
      press(10);
      check("on_state", int'(bus.state), 1);
      press(1); press(2); press(3); press(4);
      check("led_1234", int'(bus.password_led), 6'b111100);
      press(11);
      check("open_state", int'(bus.state), 4);

      // Three wrong attempts lock the safe; lock ignores everything
      press(10); press(10);
      for (int a = 0; a < 3; a++) begin
         press(9); press(9); press(11);
      end
      check("lock_state", int'(bus.state), 7);
      press(10); press(5); pulse_rp();
      check("lock_stays", int'(bus.state), 7);
      do_reset();

      // Key held while rows wander produces a single digit
      press(10);
      set_key(7);
      for (int c = 0; c < 100; c++) begin
         if (c >= 5) begin
            {bus.row4, bus.row3, bus.row2, bus.row1} = 4'($urandom);
         end
         tick(1);
      end
      model_key(7);
      release_keys();
      tick(3);
      check_out("hold");
      check("hold_led", int'(bus.password_led), 6'b100000);
      press(7);
      check("hold_led2", int'(bus.password_led), 6'b110000);
      press(10);

      // Length mismatch and empty entry
      press(10);
      press(1); press(2); press(3); press(11);
      check("short_pw", int'(bus.state), 2);
      press(11);
      check("empty_hash", int'(bus.state), 2);
      enter_pw();

      // Password change with a seventh digit ignored
      pulse_rp();
      check("reset_state", int'(bus.state), 5);
      foreach (m_pw[i]) ;
      press(5); press(6); press(7); press(8); press(9); press(0); press(1);
      check("led_full", int'(bus.password_led), 6'b111111);
      press(11);
      check("new_pw_on", int'(bus.state), 1);
      press(1); press(2); press(3); press(4); press(11);
      check("old_pw_bad", int'(bus.state), 2);
      press(5); press(6); press(7); press(8); press(9); press(0); press(11);
      check("new_pw_ok", int'(bus.state), 4);

      // Abort keeps the old password; rp beats star in the same cycle
      pulse_rp();
      press(4); press(10);
      check("abort_open", int'(bus.state), 4);
      press(10); press(10);
      enter_pw();
      check("abort_pw_kept", int'(bus.state), 4);
      star_and_rp();
      check("rp_priority", int'(bus.state), 5);
      press(10);

      // Random traffic against the model
      for (int it = 0; it < 400; it++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 8) pulse_rp();
         else if (r < 16) enter_pw();
         else if (r < 19) do_reset();
         else if (r < 22) star_and_rp();
         else if (m_state == 7 && r < 40) do_reset();
         else press(int'($urandom_range(0, 11)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
